fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the fetch PC and sequences instruction fetch over a single-outstanding
//  req/gnt/rvalid instruction-memory port. Applies branch/JAL/JALR redirects,
//  including ones that arrive while a fetch is in flight, and presents one
//  instruction at a time to decode over a valid/ready handshake.
// PARAMETERS
//  width_p    32          address/PC and instruction width
//  reset_pc_p 32'h0       fetch PC loaded on reset
//  cnt_w_p    16          width of flush counter (saturating)
// PORTS
//  clk_i              in   1        clock, rising edge
//  rst_ni             in   1        async active-low reset
//  redirect_i         in   1        take redirect this cycle (branch/JAL/JALR)
//  redirect_target_i  in   width_p  redirect target; bits[1:0] forced to 0
//  imem_req_o         out  1        fetch request
//  imem_addr_o        out  width_p  fetch address (= fetch_pc)
//  imem_gnt_i         in   1        request accepted this cycle
//  imem_rvalid_i      in   1        response valid
//  imem_rdata_i       in   width_p  response instruction
//  instr_valid_o      out  1        instruction available to decode
//  instr_ready_i      in   1        decode accepts instruction
//  instr_o            out  width_p  held instruction
//  instr_pc_o         out  width_p  PC of held instruction
//  flush_cnt_o        out  cnt_w_p  count of discarded fetches, saturates
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE, fetch_pc=reset_pc_p,
//   instr_o=0, instr_pc_o=0, flush_cnt_o=0; all outputs low/zero.
//   Reset mid-fetch aborts everything; the stale rvalid is ignored (see below).
//  imem_req_o=1 only in REQ; instr_valid_o=1 only in HOLD; imem_addr_o=fetch_pc.
//  redirect_i has priority over every other event in every state except IDLE:
//   fetch_pc <= {redirect_target_i[w-1:2],2'b00}.
//  States / transitions (evaluated each rising edge):
//   IDLE  -> REQ unconditionally (one cycle after reset release).
//   REQ   redirect&gnt -> DRAIN, flush_cnt++ (granted fetch is stale);
//         redirect&!gnt -> REQ (address retargets; memory samples addr at gnt);
//         gnt -> WAIT; else stay.
//   WAIT  redirect&rvalid -> REQ, response dropped, flush_cnt++;
//         redirect&!rvalid -> DRAIN, flush_cnt++;
//         rvalid -> HOLD: instr_o<=rdata, instr_pc_o<=fetch_pc,
//                   fetch_pc<=fetch_pc+4 (wraps mod 2^width_p); else stay.
//   DRAIN rvalid -> REQ (response discarded); redirect updates fetch_pc, stays
//         DRAIN, no extra count; else stay.
//   HOLD  redirect -> REQ, held instr dropped, flush_cnt++ (even if ready=1);
//         ready -> REQ; else stay, instr_o/instr_pc_o stable.
//  imem_rvalid_i in IDLE/REQ/HOLD is ignored. flush_cnt_o saturates at all-ones.
//  Best-case throughput: 1 instr per 3 cycles (REQ+gnt, WAIT+rvalid, HOLD+ready).
//  Latency: rvalid at edge N -> instr_valid_o high from after edge N.
// TESTING
//  1 Reset, gnt tied 1, rvalid 1 cycle after gnt, ready=1 -> addrs 0,4,8,...
//    issued; instr_pc_o tracks; no req in first cycle after reset release.
//  2 ready=0 for 5 cycles in HOLD -> instr_o/instr_pc_o stable, no new req.
//  3 redirect to 0x103 in WAIT, rvalid 2 cycles later -> rdata discarded, next
//    req addr=0x100, flush_cnt_o=1, instr_valid_o never asserts for dropped one.
//  4 redirect and gnt same cycle in REQ -> DRAIN; next rvalid dropped; req to target.
//  5 Two redirects (0x40 then 0x80) while in DRAIN -> next req addr=0x80, count=1.
//  6 reset_pc_p=32'hFFFF_FFFC -> second fetch addr wraps to 0; async reset mid-WAIT
//    -> outputs zero immediately, late rvalid ignored, fetch restarts at reset_pc_p.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bundle between fetch_sequencer (master) and its environment:
// redirect input, req/gnt/rvalid memory port and the decode handoff.
interface fetch_sequencer_if #(
    parameter int width_p = 32,
    parameter int cnt_w_p = 16
);
    // Decode handoff is strict valid/ready: an instruction transfers on a cycle
    // where instr_valid_o & instr_ready_i; while valid and not ready, instr_o and
    // instr_pc_o hold stable. Memory side: the address is taken at req & gnt and
    // exactly one rvalid follows, with at most one fetch outstanding.
    logic               redirect_i;
    logic [width_p-1:0] redirect_target_i;
    logic               imem_req_o;
    logic [width_p-1:0] imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [width_p-1:0] imem_rdata_i;
    logic               instr_valid_o;
    logic               instr_ready_i;
    logic [width_p-1:0] instr_o;
    logic [width_p-1:0] instr_pc_o;
    logic [cnt_w_p-1:0] flush_cnt_o;

    modport master (
        input  redirect_i, redirect_target_i, imem_gnt_i, imem_rvalid_i,
               imem_rdata_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
               flush_cnt_o
    );

    modport slave (
        output redirect_i, redirect_target_i, imem_gnt_i, imem_rvalid_i,
               imem_rdata_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
               flush_cnt_o
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: single-outstanding instruction fetch with redirect handling
// (including in-flight redirects) and a one-entry hold buffer towards decode.
module fetch_sequencer #(
    parameter int                 width_p    = 32,
    parameter logic [width_p-1:0] reset_pc_p = '0,
    parameter int                 cnt_w_p    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fetch_sequencer_if.master   bus,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [width_p-1:0] fetch_pc_q, fetch_pc_d;
    logic [width_p-1:0] instr_q, instr_d;
    logic [width_p-1:0] instr_pc_q, instr_pc_d;
    logic [cnt_w_p-1:0] flush_cnt_q, flush_cnt_d;
    logic               flush_inc;
    logic [width_p-1:0] target;

    assign target = bus.redirect_target_i & ~width_p'(3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= reset_pc_p;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        flush_inc   = 1'b0;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (bus.redirect_i) begin
                    fetch_pc_d = target;
                    if (bus.imem_gnt_i) begin
                        state_d   = ST_DRAIN;
                        flush_inc = 1'b1;
                    end
                end else if (bus.imem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.redirect_i) begin
                    fetch_pc_d = target;
                    flush_inc  = 1'b1;
                    state_d    = bus.imem_rvalid_i ? ST_REQ : ST_DRAIN;
                end else if (bus.imem_rvalid_i) begin
                    state_d    = ST_HOLD;
                    instr_d    = bus.imem_rdata_i;
                    instr_pc_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + width_p'(4);
                end
            end
            ST_DRAIN: begin
                // The stale fetch was already counted; a redirect only retargets,
                // and the discarded response still ends the drain.
                if (bus.redirect_i) fetch_pc_d = target;
                if (bus.imem_rvalid_i) state_d = ST_REQ;
            end
            ST_HOLD: begin
                if (bus.redirect_i) begin
                    fetch_pc_d = target;
                    flush_inc  = 1'b1;
                    state_d    = ST_REQ;
                end else if (bus.instr_ready_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + cnt_w_p'(1);
    end

    assign bus.imem_req_o    = (state_q == ST_REQ);
    assign bus.imem_addr_o   = fetch_pc_q;
    assign bus.instr_valid_o = (state_q == ST_HOLD);
    assign bus.instr_o       = instr_q;
    assign bus.instr_pc_o    = instr_pc_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand sequences for wrap,
// async reset and saturation, and random traffic against a transaction model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.width_p(32), .cnt_w_p(16)) bus_a ();
    fetch_sequencer_if #(.width_p(32), .cnt_w_p(3))  bus_b ();
    logic [2:0] dbg_a, dbg_b;

    fetch_sequencer #(.width_p(32), .reset_pc_p(32'h0), .cnt_w_p(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a.master), .dbg_state_o(dbg_a));
    fetch_sequencer #(.width_p(32), .reset_pc_p(32'hFFFF_FFFC), .cnt_w_p(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b.master), .dbg_state_o(dbg_b));

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_a(input logic redir, input logic [31:0] tgt, input logic gnt,
                           input logic rv, input logic [31:0] rdata, input logic rdy);
        bus_a.redirect_i        = redir;
        bus_a.redirect_target_i = tgt;
        bus_a.imem_gnt_i        = gnt;
        bus_a.imem_rvalid_i     = rv;
        bus_a.imem_rdata_i      = rdata;
        bus_a.instr_ready_i     = rdy;
    endtask

    task automatic drive_b(input logic redir, input logic [31:0] tgt, input logic gnt,
                           input logic rv, input logic [31:0] rdata, input logic rdy);
        bus_b.redirect_i        = redir;
        bus_b.redirect_target_i = tgt;
        bus_b.imem_gnt_i        = gnt;
        bus_b.imem_rvalid_i     = rv;
        bus_b.imem_rdata_i      = rdata;
        bus_b.instr_ready_i     = rdy;
    endtask

    task automatic do_reset();
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic add(input logic redir, input logic [31:0] tgt, input logic gnt,
                       input logic rv, input logic [31:0] rdata, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr, input logic e_val,
                       input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic [31:0] e_cnt);
        vec_t v;
        v.redir = redir; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3C3_5A5A;
    endfunction

    initial begin
        // Each row: inputs held across one edge, then outputs expected after it.
        //   redir tgt          gnt rv rdata          rdy  req addr         val instr          pc           cnt
        add(0, 0,            0, 0, 0,             0,   1, 32'h0,       0, 32'h0,         32'h0,       0); // IDLE->REQ
        add(0, 0,            1, 0, 0,             0,   0, 32'h0,       0, 32'h0,         32'h0,       0);
        add(0, 0,            0, 1, 32'h1111_1111, 1,   0, 32'h4,       1, 32'h1111_1111, 32'h0,       0);
        add(0, 0,            0, 0, 0,             1,   1, 32'h4,       0, 32'h1111_1111, 32'h0,       0);
        add(0, 0,            1, 0, 0,             1,   0, 32'h4,       0, 32'h1111_1111, 32'h0,       0);
        add(0, 0,            0, 1, 32'h2222_2222, 0,   0, 32'h8,       1, 32'h2222_2222, 32'h4,       0);
        for (int i = 0; i < 5; i++)
            add(0, 0,        0, 0, 0,             0,   0, 32'h8,       1, 32'h2222_2222, 32'h4,       0); // stall
        add(0, 0,            0, 0, 0,             1,   1, 32'h8,       0, 32'h2222_2222, 32'h4,       0);
        add(0, 0,            1, 0, 0,             0,   0, 32'h8,       0, 32'h2222_2222, 32'h4,       0);
        add(1, 32'h103,      0, 0, 0,             0,   0, 32'h100,     0, 32'h2222_2222, 32'h4,       1); // WAIT redirect
        add(0, 0,            0, 0, 0,             0,   0, 32'h100,     0, 32'h2222_2222, 32'h4,       1);
        add(0, 0,            0, 1, 32'hDEAD_BEEF, 1,   1, 32'h100,     0, 32'h2222_2222, 32'h4,       1);
        add(1, 32'h200,      1, 0, 0,             0,   0, 32'h200,     0, 32'h2222_2222, 32'h4,       2); // redirect+gnt
        add(0, 0,            0, 1, 32'hDEAD_0001, 1,   1, 32'h200,     0, 32'h2222_2222, 32'h4,       2);
        add(0, 0,            1, 0, 0,             0,   0, 32'h200,     0, 32'h2222_2222, 32'h4,       2);
        add(1, 32'h40,       0, 0, 0,             0,   0, 32'h40,      0, 32'h2222_2222, 32'h4,       3);
        add(1, 32'h80,       0, 0, 0,             0,   0, 32'h80,      0, 32'h2222_2222, 32'h4,       3); // DRAIN retarget
        add(0, 0,            0, 1, 32'hDEAD_0002, 0,   1, 32'h80,      0, 32'h2222_2222, 32'h4,       3);
        add(0, 0,            1, 0, 0,             0,   0, 32'h80,      0, 32'h2222_2222, 32'h4,       3);
        add(0, 0,            0, 1, 32'h3333_3333, 0,   0, 32'h84,      1, 32'h3333_3333, 32'h80,      3);
        add(1, 32'h10,       0, 0, 0,             1,   1, 32'h10,      0, 32'h3333_3333, 32'h80,      4); // HOLD redirect
        add(1, 32'h22,       0, 0, 0,             0,   1, 32'h20,      0, 32'h3333_3333, 32'h80,      4); // REQ retarget
        add(0, 0,            1, 0, 0,             0,   0, 32'h20,      0, 32'h3333_3333, 32'h80,      4);
        add(1, 32'h30,       0, 1, 32'hDEAD_0003, 0,   1, 32'h30,      0, 32'h3333_3333, 32'h80,      5);

        // Reset state, then the directed table
        do_reset();
        chk("rst_req", 32'(bus_a.imem_req_o), 0);
        chk("rst_val", 32'(bus_a.instr_valid_o), 0);
        chk("rst_instr", bus_a.instr_o, 0);
        chk("rst_pc", bus_a.instr_pc_o, 0);
        chk("rst_cnt", 32'(bus_a.flush_cnt_o), 0);
        chk("rst_addr", bus_a.imem_addr_o, 0);
        foreach (vecs[i]) begin
            drive_a(vecs[i].redir, vecs[i].tgt, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
            step();
            chk($sformatf("v%0d_req", i), 32'(bus_a.imem_req_o), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), bus_a.imem_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d_val", i), 32'(bus_a.instr_valid_o), 32'(vecs[i].e_val));
            chk($sformatf("v%0d_instr", i), bus_a.instr_o, vecs[i].e_instr);
            chk($sformatf("v%0d_pc", i), bus_a.instr_pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d_cnt", i), 32'(bus_a.flush_cnt_o), vecs[i].e_cnt);
        end
        drive_a(0, 0, 0, 0, 0, 0);

        // Wrap of the fetch PC, then async reset in the middle of WAIT
        do_reset();
        chk("w_rst_addr", bus_b.imem_addr_o, 32'hFFFF_FFFC);
        chk("w_rst_req", 32'(bus_b.imem_req_o), 0);
        step();
        chk("w_req", 32'(bus_b.imem_req_o), 1);
        drive_b(0, 0, 1, 0, 0, 0); step();
        drive_b(0, 0, 0, 1, 32'h0000_ABCD, 0); step();
        chk("w_val", 32'(bus_b.instr_valid_o), 1);
        chk("w_instr", bus_b.instr_o, 32'h0000_ABCD);
        chk("w_pc", bus_b.instr_pc_o, 32'hFFFF_FFFC);
        chk("w_addr_wrap", bus_b.imem_addr_o, 32'h0);
        drive_b(0, 0, 0, 0, 0, 1); step();
        chk("w_req2", 32'(bus_b.imem_req_o), 1);
        chk("w_addr2", bus_b.imem_addr_o, 32'h0);
        drive_b(0, 0, 1, 0, 0, 0); step();
        chk("w_wait_req", 32'(bus_b.imem_req_o), 0);
        drive_b(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", 32'(bus_b.imem_req_o), 0);
        chk("ar_val", 32'(bus_b.instr_valid_o), 0);
        chk("ar_instr", bus_b.instr_o, 0);
        chk("ar_pc", bus_b.instr_pc_o, 0);
        chk("ar_addr", bus_b.imem_addr_o, 32'hFFFF_FFFC);
        drive_b(0, 0, 0, 1, 32'h0BAD_0BAD, 1);
        step(); step();
        rst_n = 1'b1;
        chk("ar_idle_req", 32'(bus_b.imem_req_o), 0);
        step();
        chk("ar_req_after", 32'(bus_b.imem_req_o), 1);
        chk("ar_addr_after", bus_b.imem_addr_o, 32'hFFFF_FFFC);
        chk("ar_val_after", 32'(bus_b.instr_valid_o), 0);
        step();
        chk("ar_late_rv_ignored", 32'(bus_b.instr_valid_o), 0);
        chk("ar_still_req", 32'(bus_b.imem_req_o), 1);

        // Flush counter saturation (3-bit counter)
        for (int i = 0; i < 9; i++) begin
            drive_b(1, 32'((i + 1) * 16), 1, 0, 0, 0); step();
            chk($sformatf("sat_cnt%0d", i), 32'(bus_b.flush_cnt_o), (i < 7) ? 32'(i + 1) : 32'd7);
            drive_b(0, 0, 0, 1, 0, 0); step();
        end
        chk("sat_addr", bus_b.imem_addr_o, 32'h90);
        drive_b(0, 0, 0, 0, 0, 0);

        // Random traffic against a transaction-level model
        begin
            bit          outstanding, flushed, held, live, redir, gnt, rv, rdy;
            logic [31:0] out_addr, hold_pc, tgt, cnt, pc_exp;
            int          delay, accepts;
            outstanding = 0; flushed = 0; held = 0; cnt = 0; delay = 0; accepts = 0;
            out_addr = 0; hold_pc = 0;
            exp_q.delete();
            exp_q.push_back(32'h0);
            do_reset();
            step();
            for (int c = 0; c < 3000; c++) begin
                redir = ($urandom_range(0, 7) == 0);
                tgt   = $urandom;
                gnt   = bus_a.imem_req_o && !outstanding && ($urandom_range(0, 9) < 6);
                rv    = outstanding && (delay == 0);
                rdy   = ($urandom_range(0, 3) != 0);
                drive_a(redir, tgt, gnt, rv, mem_word(out_addr), rdy);
                live = (bus_a.imem_req_o && gnt) || (outstanding && !flushed) || held;
                if (held && rdy && !redir) begin
                    pc_exp = exp_q.pop_front();
                    chk("rnd_accept_pc", bus_a.instr_pc_o, pc_exp);
                    exp_q.push_back(pc_exp + 32'd4);
                    held = 0;
                    accepts++;
                end
                if (outstanding && rv) begin
                    outstanding = 0;
                    if (!flushed && !redir) begin
                        held = 1;
                        hold_pc = out_addr;
                    end
                end else if (outstanding) begin
                    delay--;
                end
                if (redir) begin
                    if (live && cnt != 32'hFFFF) cnt++;
                    held = 0;
                    flushed = 1;
                    exp_q.delete();
                    exp_q.push_back(tgt & ~32'd3);
                end
                if (bus_a.imem_req_o && gnt) begin
                    outstanding = 1;
                    flushed = redir;
                    out_addr = bus_a.imem_addr_o;
                    delay = $urandom_range(0, 3);
                end
                step();
                chk("rnd_cnt", 32'(bus_a.flush_cnt_o), cnt);
                chk("rnd_val", 32'(bus_a.instr_valid_o), 32'(held));
                if (held) begin
                    chk("rnd_instr", bus_a.instr_o, mem_word(hold_pc));
                    chk("rnd_hold_pc", bus_a.instr_pc_o, hold_pc);
                end
                chk("rnd_req", 32'(bus_a.imem_req_o), 32'(!outstanding && !held));
                if (bus_a.imem_req_o) chk("rnd_addr", bus_a.imem_addr_o, exp_q[0]);
            end
            chk("rnd_accepts_seen", 32'(accepts > 0), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
